// File: rtl/bids22_settle.sv
// Settlement stage behind the bids22 auction controller.
// Each rising edge of roundOver starts a three-state sequence:
//   IDLE  - capture the round result
//   DEBIT - charge the winning bidder's ledger
//   PUSH  - log one record into a first-word-fall-through FIFO
// FIFO handshake: rec_valid means rec_* holds the head record; rd_ack pops it in the
// same cycle and is ignored while rec_valid is low. There is no backpressure on the
// write side: a PUSH into a full FIFO drops the record and sets the sticky drop_err.
module bids22_settle #(
    parameter int DEPTH = 8,
    parameter int AMT_W = 16,
    parameter int BAL_W = 32,
    parameter int RND_W = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     roundOver,
    input  logic                     X_win,
    input  logic                     Y_win,
    input  logic                     Z_win,
    input  logic [AMT_W-1:0]         maxBid,
    input  logic [2:0]               err,
    input  logic                     load_en,
    input  logic [1:0]               load_sel,
    input  logic [BAL_W-1:0]         load_data,
    input  logic                     rd_ack,
    input  logic                     clr_err,
    output logic [BAL_W-1:0]         X_balance,
    output logic [BAL_W-1:0]         Y_balance,
    output logic [BAL_W-1:0]         Z_balance,
    output logic                     rec_valid,
    output logic [RND_W-1:0]         rec_round,
    output logic [1:0]               rec_winner,
    output logic [AMT_W-1:0]         rec_amount,
    output logic                     rec_nsf,
    output logic                     fifo_full,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     drop_err,
    output logic                     miss_err,
    output logic                     busy
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int REC_W = RND_W + 2 + AMT_W + 1;

    typedef enum logic [1:0] {IDLE, DEBIT, PUSH} state_t;

    state_t             state;
    logic               ro_q;
    logic [1:0]         win_q;
    logic [AMT_W-1:0]   amt_q;
    logic               nsf_q;
    logic [RND_W-1:0]   round_q;
    logic [BAL_W-1:0]   bal [3];
    logic [REC_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;

    logic               trig;
    logic [1:0]         win_dec;
    logic [AMT_W-1:0]   amt_dec;
    logic [BAL_W-1:0]   sel_bal;
    logic               short_funds;
    logic               debit_ok;
    logic               push;
    logic               pop;
    logic               full;
    logic               push_ok;
    logic               drop;
    logic [REC_W-1:0]   head;

    assign trig = roundOver & ~ro_q;

    // Winner decode: a single win flag and no duplicate-bid error, otherwise no winner.
    always_comb begin
        win_dec = 2'd0;
        if (err != 3'b101) begin
            case ({Z_win, Y_win, X_win})
                3'b001:  win_dec = 2'd1;
                3'b010:  win_dec = 2'd2;
                3'b100:  win_dec = 2'd3;
                default: win_dec = 2'd0;
            endcase
        end
        amt_dec = (win_dec != 2'd0) ? maxBid : '0;
    end

    // Balance of the captured winner, for the funds check in DEBIT.
    always_comb begin
        case (win_q)
            2'd1:    sel_bal = bal[0];
            2'd2:    sel_bal = bal[1];
            2'd3:    sel_bal = bal[2];
            default: sel_bal = '0;
        endcase
    end

    assign short_funds = sel_bal < BAL_W'(amt_q);
    assign debit_ok    = (state == DEBIT) && (win_q != 2'd0) && !short_funds;

    // Sequencer: capture on the trigger edge, then DEBIT and PUSH for one cycle each.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            ro_q  <= 1'b0;
            win_q <= 2'd0;
            amt_q <= '0;
            nsf_q <= 1'b0;
        end else begin
            ro_q <= roundOver;
            case (state)
                IDLE: begin
                    if (trig) begin
                        win_q <= win_dec;
                        amt_q <= amt_dec;
                        state <= DEBIT;
                    end
                end
                DEBIT: begin
                    // nsf always reflects the balance before any same-cycle load.
                    nsf_q <= (win_q != 2'd0) && short_funds;
                    state <= PUSH;
                end
                PUSH:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Ledgers: a host load overrides a same-cycle debit of the same bidder.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 3; i++) bal[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (load_en && (load_sel == 2'(i)))
                    bal[i] <= load_data;
                else if (debit_ok && (win_q == 2'(i + 1)))
                    bal[i] <= bal[i] - BAL_W'(amt_q);
            end
        end
    end

    assign push    = (state == PUSH);
    assign pop     = rd_ack && (count != '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign push_ok = push && (!full || pop);
    assign drop    = push && !push_ok;

    // Record storage; only the slots between the pointers are ever observed.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= {round_q, win_q, amt_q, nsf_q};
    end

    // FIFO pointers, occupancy and the round counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            round_q <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            if (push_ok && !pop)      count <= count + CNT_W'(1);
            else if (!push_ok && pop) count <= count - CNT_W'(1);
            if (push) round_q <= round_q + RND_W'(1);
        end
    end

    // Sticky status bits; a new event in the same cycle beats clr_err.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_err <= 1'b0;
            miss_err <= 1'b0;
        end else begin
            if (drop)         drop_err <= 1'b1;
            else if (clr_err) drop_err <= 1'b0;
            if (trig && (state != IDLE)) miss_err <= 1'b1;
            else if (clr_err)            miss_err <= 1'b0;
        end
    end

    assign head       = mem[rd_ptr];
    assign rec_valid  = (count != '0);
    assign rec_round  = rec_valid ? head[REC_W-1 -: RND_W] : '0;
    assign rec_winner = rec_valid ? head[AMT_W+2 -: 2] : 2'd0;
    assign rec_amount = rec_valid ? head[AMT_W:1] : '0;
    assign rec_nsf    = rec_valid ? head[0] : 1'b0;
    assign fifo_full  = full;
    assign fifo_count = count;
    assign X_balance  = bal[0];
    assign Y_balance  = bal[1];
    assign Z_balance  = bal[2];
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_bids22_settle.sv
// Directed bench for bids22_settle: a reference ledger/FIFO model predicts each
// record, expected records are queued at stimulus time and compared when popped.
`timescale 1ns/1ps
module tb_bids22_settle;
    localparam int DEPTH = 8;
    localparam int REC_W = 8 + 2 + 16 + 1;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        roundOver, X_win, Y_win, Z_win;
    logic [15:0] maxBid;
    logic [2:0]  err;
    logic        load_en;
    logic [1:0]  load_sel;
    logic [31:0] load_data;
    logic        rd_ack, clr_err;
    logic [31:0] X_balance, Y_balance, Z_balance;
    logic        rec_valid;
    logic [7:0]  rec_round;
    logic [1:0]  rec_winner;
    logic [15:0] rec_amount;
    logic        rec_nsf, fifo_full;
    logic [3:0]  fifo_count;
    logic        drop_err, miss_err, busy;

    // reference model state
    logic [REC_W-1:0] exp_q[$];
    logic [31:0]      bal_m [3];
    logic [7:0]       round_m;
    int               cnt_m;
    logic             drop_m;
    int               n_cmp = 0;
    int               n_mis = 0;

    bids22_settle #(.DEPTH(DEPTH), .AMT_W(16), .BAL_W(32), .RND_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .roundOver(roundOver),
        .X_win(X_win), .Y_win(Y_win), .Z_win(Z_win), .maxBid(maxBid), .err(err),
        .load_en(load_en), .load_sel(load_sel), .load_data(load_data),
        .rd_ack(rd_ack), .clr_err(clr_err),
        .X_balance(X_balance), .Y_balance(Y_balance), .Z_balance(Z_balance),
        .rec_valid(rec_valid), .rec_round(rec_round), .rec_winner(rec_winner),
        .rec_amount(rec_amount), .rec_nsf(rec_nsf), .fifo_full(fifo_full),
        .fifo_count(fifo_count), .drop_err(drop_err), .miss_err(miss_err), .busy(busy)
    );

    // clock
    always #5 clk = ~clk;

    // watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] dec(input logic x, input logic y, input logic z, input logic [2:0] e);
        if (e == 3'b101) return 2'd0;
        case ({z, y, x})
            3'b001:  return 2'd1;
            3'b010:  return 2'd2;
            3'b100:  return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [REC_W-1:0] head_obs();
        return {rec_round, rec_winner, rec_amount, rec_nsf};
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        roundOver = 1'b0; X_win = 1'b0; Y_win = 1'b0; Z_win = 1'b0;
        maxBid = '0; err = '0; load_en = 1'b0; load_sel = '0; load_data = '0;
        rd_ack = 1'b0; clr_err = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        exp_q.delete();
        for (int i = 0; i < 3; i++) bal_m[i] = '0;
        round_m = '0; cnt_m = 0; drop_m = 1'b0;
    endtask

    task automatic load(input int sel, input logic [31:0] val);
        load_en = 1'b1; load_sel = 2'(sel); load_data = val;
        @(negedge clk);
        load_en = 1'b0;
        bal_m[sel] = val;
    endtask

    task automatic do_clr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        drop_m = 1'b0;
    endtask

    // One round. ld_mode: 0 none, 1 load winner on trigger cycle, 2 load winner during DEBIT.
    task automatic do_round(input logic x, input logic y, input logic z, input logic [15:0] amt,
                            input logic [2:0] e, input int ld_mode, input logic [31:0] ld_val,
                            input bit ack);
        logic [1:0]  w;
        logic [15:0] a;
        logic        nsf;
        int          idx;
        w = dec(x, y, z, e);
        a = (w != 2'd0) ? amt : 16'd0;
        idx = int'(w) - 1;
        roundOver = 1'b1; X_win = x; Y_win = y; Z_win = z; maxBid = amt; err = e;
        if (ld_mode == 1 && w != 2'd0) begin
            load_en = 1'b1; load_sel = 2'(idx); load_data = ld_val; bal_m[idx] = ld_val;
        end
        @(negedge clk);
        roundOver = 1'b0; X_win = 1'b0; Y_win = 1'b0; Z_win = 1'b0; maxBid = '0; err = '0;
        load_en = 1'b0;
        check("busy_debit", 32'(busy), 32'd1);
        nsf = 1'b0;
        if (w != 2'd0) begin
            if (bal_m[idx] >= {16'd0, a}) bal_m[idx] = bal_m[idx] - {16'd0, a};
            else nsf = 1'b1;
        end
        if (ld_mode == 2 && w != 2'd0) begin
            load_en = 1'b1; load_sel = 2'(idx); load_data = ld_val; bal_m[idx] = ld_val;
        end
        @(negedge clk);
        load_en = 1'b0;
        check("x_balance", X_balance, bal_m[0]);
        check("y_balance", Y_balance, bal_m[1]);
        check("z_balance", Z_balance, bal_m[2]);
        if (ack) begin
            check("ack_head", 32'(head_obs()), 32'(exp_q[0]));
            rd_ack = 1'b1;
        end
        @(negedge clk);
        rd_ack = 1'b0;
        if (ack && exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            cnt_m--;
        end
        if (cnt_m < DEPTH) begin
            exp_q.push_back({round_m, w, a, nsf});
            cnt_m++;
        end else begin
            drop_m = 1'b1;
        end
        round_m = round_m + 8'd1;
        check("drop_err", 32'(drop_err), 32'(drop_m));
        check("fifo_count", 32'(fifo_count), 32'(cnt_m));
    endtask

    task automatic pop_check(input string tag);
        check({tag, "_valid"}, 32'(rec_valid), 32'd1);
        check({tag, "_qnonempty"}, 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            check({tag, "_rec"}, 32'(head_obs()), 32'(exp_q.pop_front()));
            cnt_m--;
        end
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
    endtask

    initial begin
        do_reset();
        // reset state
        check("rst_x", X_balance, 32'd0);
        check("rst_y", Y_balance, 32'd0);
        check("rst_z", Z_balance, 32'd0);
        check("rst_valid", 32'(rec_valid), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_full", 32'(fifo_full), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_drop", 32'(drop_err), 32'd0);
        check("rst_miss", 32'(miss_err), 32'd0);
        check("rst_rec", 32'(head_obs()), 32'd0);

        // basic debit
        load(0, 100); load(1, 50); load(2, 20);
        do_round(1, 0, 0, 16'd30, 3'd0, 0, 0, 0);
        check("t1_xbal", X_balance, 32'd70);
        check("t1_rec", 32'(head_obs()), 32'({8'd0, 2'd1, 16'd30, 1'b0}));
        pop_check("t1");

        // insufficient funds
        do_round(0, 1, 0, 16'd60, 3'd0, 0, 0, 0);
        check("t2_ybal", Y_balance, 32'd50);
        check("t2_nsf", 32'(rec_nsf), 32'd1);
        pop_check("t2");

        // no-winner combinations
        do_round(1, 0, 0, 16'd40, 3'b101, 0, 0, 0);
        pop_check("t3_dup");
        do_round(1, 1, 0, 16'd40, 3'd0, 0, 0, 0);
        pop_check("t3_two");

        // loads racing the debit
        do_round(0, 0, 1, 16'd5, 3'd0, 2, 32'd500, 0);
        check("ld_debit_z", Z_balance, 32'd500);
        pop_check("ld_debit");
        do_round(0, 1, 0, 16'd70, 3'd0, 2, 32'd80, 0);
        check("ld_debit_nsf", 32'(rec_nsf), 32'd1);
        pop_check("ld_debit_nsf");
        do_round(0, 0, 1, 16'd600, 3'd0, 1, 32'd1000, 0);
        check("ld_trig_z", Z_balance, 32'd400);
        pop_check("ld_trig");

        // fill to full, drop, then push+pop while full
        do_reset();
        load(0, 100);
        for (int i = 0; i < 8; i++) do_round(1, 0, 0, 16'd1, 3'd0, 0, 0, 0);
        check("t4_full", 32'(fifo_full), 32'd1);
        check("t4_nodrop", 32'(drop_err), 32'd0);
        do_round(1, 0, 0, 16'd1, 3'd0, 0, 0, 0);
        check("t4_drop", 32'(drop_err), 32'd1);
        check("t4_head_round", 32'(rec_round), 32'd0);
        do_clr();
        check("t4_clr", 32'(drop_err), 32'd0);
        do_round(1, 0, 0, 16'd2, 3'd0, 0, 0, 1);
        check("t4_ack_nodrop", 32'(drop_err), 32'd0);
        check("t4_ack_full", 32'(fifo_full), 32'd1);
        for (int i = 0; i < DEPTH; i++) pop_check("t4_drain");
        check("t4_empty", 32'(rec_valid), 32'd0);

        // held roundOver gives one record; an edge during PUSH is missed
        roundOver = 1'b1;
        repeat (3) @(negedge clk);
        roundOver = 1'b0;
        @(negedge clk);
        exp_q.push_back({round_m, 2'd0, 16'd0, 1'b0});
        round_m = round_m + 8'd1; cnt_m++;
        check("t5_hold_count", 32'(fifo_count), 32'd1);
        check("t5_hold_miss", 32'(miss_err), 32'd0);
        pop_check("t5_hold");
        roundOver = 1'b1; X_win = 1'b1; maxBid = 16'd10;
        @(negedge clk);
        roundOver = 1'b0; X_win = 1'b0; maxBid = '0;
        @(negedge clk);
        roundOver = 1'b1;
        @(negedge clk);
        roundOver = 1'b0;
        check("t5_miss", 32'(miss_err), 32'd1);
        @(negedge clk);
        check("t5_idle", 32'(busy), 32'd0);
        if (bal_m[0] >= 32'd10) begin
            bal_m[0] = bal_m[0] - 32'd10;
            exp_q.push_back({round_m, 2'd1, 16'd10, 1'b0});
        end else begin
            exp_q.push_back({round_m, 2'd1, 16'd10, 1'b1});
        end
        round_m = round_m + 8'd1; cnt_m++;
        check("t5_count", 32'(fifo_count), 32'd1);
        check("t5_xbal", X_balance, bal_m[0]);
        do_clr();
        check("t5_clr", 32'(miss_err), 32'd0);
        pop_check("t5_edge");

        // reset during DEBIT
        do_round(0, 0, 0, 16'd0, 3'd0, 0, 0, 0);
        roundOver = 1'b1; X_win = 1'b1; maxBid = 16'd10;
        @(negedge clk);
        roundOver = 1'b0; X_win = 1'b0; maxBid = '0;
        check("t6_in_debit", 32'(busy), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("t6_xbal", X_balance, 32'd0);
        check("t6_count", 32'(fifo_count), 32'd0);
        check("t6_valid", 32'(rec_valid), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_after_valid", 32'(rec_valid), 32'd0);
        check("t6_after_xbal", X_balance, 32'd0);
        exp_q.delete();
        for (int i = 0; i < 3; i++) bal_m[i] = '0;
        round_m = '0; cnt_m = 0; drop_m = 1'b0;

        // round counter wrap with randomized results
        load(0, 60000); load(1, 60000); load(2, 60000);
        for (int i = 0; i < 256; i++) begin
            do_round(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     16'($urandom_range(0, 1000)), 3'($urandom_range(0, 7)), 0, 0, 0);
            pop_check("t7");
        end
        do_round(1, 0, 0, 16'd3, 3'd0, 0, 0, 0);
        check("t7_wrap", 32'(rec_round), 32'd0);
        pop_check("t7_wrap");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
